// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with optional skid entry, flush and stall counter
module pipe_stage_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 111,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    localparam bit SKID_EN = (SKID != 0);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t              state;
    state_t              state_n;
    logic [CTRL_W-1:0]   head_ctrl;
    logic [DATA_W-1:0]   head_data;
    logic [CTRL_W-1:0]   skid_ctrl;
    logic [DATA_W-1:0]   skid_data;
    logic [CNT_W-1:0]    stall_cnt;

    logic accept;
    logic drain;
    logic load_head;
    logic load_skid;
    logic head_from_skid;

    assign valid_o     = (state != S_EMPTY);
    assign ctrl_o      = valid_o ? head_ctrl : '0;
    assign data_o      = head_data;
    assign stall_cnt_o = stall_cnt;

    // In skid mode ready_o depends only on the state register, breaking the ready_i timing path.
    always_comb begin
        if (SKID_EN) begin
            ready_o = (state != S_TWO);
        end else begin
            ready_o = ready_i | (state == S_EMPTY);
        end
    end

    assign accept = valid_i & ready_o;
    assign drain  = valid_o & ready_i;

    always_comb begin
        state_n        = state;
        load_head      = 1'b0;
        load_skid      = 1'b0;
        head_from_skid = 1'b0;
        case (state)
            S_EMPTY: begin
                if (accept) begin
                    state_n   = S_ONE;
                    load_head = 1'b1;
                end
            end
            S_ONE: begin
                if (accept && drain) begin
                    load_head = 1'b1;
                end else if (accept && SKID_EN) begin
                    state_n   = S_TWO;
                    load_skid = 1'b1;
                end else if (drain) begin
                    state_n = S_EMPTY;
                end
            end
            S_TWO: begin
                if (drain) begin
                    state_n        = S_ONE;
                    head_from_skid = 1'b1;
                end
            end
            default: state_n = S_EMPTY;
        endcase
        // A kill drops everything held plus the incoming beat; a drain this cycle has already gone out.
        if (flush_i) begin
            state_n        = S_EMPTY;
            load_head      = 1'b0;
            load_skid      = 1'b0;
            head_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_EMPTY;
            head_ctrl <= '0;
            head_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_n;
            if (load_head) begin
                head_ctrl <= ctrl_i;
                head_data <= data_i;
            end else if (head_from_skid) begin
                head_ctrl <= skid_ctrl;
                head_data <= skid_data;
            end
            if (load_skid) begin
                skid_ctrl <= ctrl_i;
                skid_data <= data_i;
            end
            if (valid_o && !ready_i && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed checks of pipe_stage_reg in skid and non-skid modes
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic         a_rst, a_valid_i, a_ready_o, a_flush, a_valid_o, a_ready_i;
    logic [7:0]   a_ctrl_i, a_ctrl_o;
    logic [110:0] a_data_i, a_data_o;
    logic [3:0]   a_stall;

    logic         b_rst, b_valid_i, b_ready_o, b_flush, b_valid_o, b_ready_i;
    logic [7:0]   b_ctrl_i, b_ctrl_o;
    logic [110:0] b_data_i, b_data_o;
    logic [15:0]  b_stall;

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(111), .SKID(1), .CNT_W(4)) u_skid (
        .clk_i(clk), .rst_i(a_rst), .valid_i(a_valid_i), .ready_o(a_ready_o),
        .ctrl_i(a_ctrl_i), .data_i(a_data_i), .flush_i(a_flush),
        .valid_o(a_valid_o), .ready_i(a_ready_i), .ctrl_o(a_ctrl_o),
        .data_o(a_data_o), .stall_cnt_o(a_stall)
    );

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(111), .SKID(0), .CNT_W(16)) u_flow (
        .clk_i(clk), .rst_i(b_rst), .valid_i(b_valid_i), .ready_o(b_ready_o),
        .ctrl_i(b_ctrl_i), .data_i(b_data_i), .flush_i(b_flush),
        .valid_o(b_valid_o), .ready_i(b_ready_i), .ctrl_o(b_ctrl_o),
        .data_o(b_data_o), .stall_cnt_o(b_stall)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_send(input logic [7:0] c, input logic [110:0] d);
        a_valid_i = 1'b1;
        a_ctrl_i  = c;
        a_data_i  = d;
    endtask

    initial begin
        a_rst = 1'b1; a_valid_i = 1'b0; a_flush = 1'b0; a_ready_i = 1'b0;
        a_ctrl_i = '0; a_data_i = '0;
        b_rst = 1'b1; b_valid_i = 1'b0; b_flush = 1'b0; b_ready_i = 1'b0;
        b_ctrl_i = '0; b_data_i = '0;
        tick();
        tick();

        check("a_rst_valid", a_valid_o, 0);
        check("a_rst_ctrl",  a_ctrl_o, 0);
        check("a_rst_data",  a_data_o, 0);
        check("a_rst_stall", a_stall, 0);
        check("a_rst_ready", a_ready_o, 1);
        check("b_rst_valid", b_valid_o, 0);
        check("b_rst_ready", b_ready_o, 1);
        a_rst = 1'b0;
        b_rst = 1'b0;

        // Streaming at full rate: each beat appears one cycle after acceptance.
        a_ready_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            a_send(8'(k), 111'(k));
            tick();
            check("stream_valid", a_valid_o, 1);
            check("stream_data",  a_data_o, k);
            check("stream_ctrl",  a_ctrl_o, k);
            check("stream_ready", a_ready_o, 1);
        end
        a_valid_i = 1'b0;
        tick();
        check("drain_valid", a_valid_o, 0);
        check("drain_ctrl0", a_ctrl_o, 0);
        check("drain_hold",  a_data_o, 4);

        // Backpressure fills the skid entry; A then B must drain in order.
        a_ready_i = 1'b0;
        a_send(8'h0A, 111'h0A);
        tick();
        check("bp_one_data",  a_data_o, 'h0A);
        check("bp_one_ready", a_ready_o, 1);
        check("bp_one_stall", a_stall, 0);
        a_send(8'h0B, 111'h0B);
        tick();
        check("bp_two_ready", a_ready_o, 0);
        check("bp_two_stall", a_stall, 1);
        check("bp_two_head",  a_data_o, 'h0A);
        a_send(8'h0C, 111'h0C);
        tick();
        check("bp_stall2", a_stall, 2);
        tick();
        check("bp_stall3", a_stall, 3);
        a_valid_i = 1'b0;
        a_ready_i = 1'b1;
        #1;
        check("bp_ready_reg", a_ready_o, 0);
        check("bp_out_a", a_data_o, 'h0A);
        tick();
        check("bp_out_b",   a_data_o, 'h0B);
        check("bp_out_b_c", a_ctrl_o, 'h0B);
        check("bp_out_b_v", a_valid_o, 1);
        check("bp_stall_k", a_stall, 3);
        tick();
        check("bp_empty", a_valid_o, 0);

        // Flush while full, with a beat offered in the same cycle.
        a_ready_i = 1'b0;
        a_send(8'h21, 111'h21);
        tick();
        a_send(8'h22, 111'h22);
        tick();
        check("fl_two_ready", a_ready_o, 0);
        check("fl_two_stall", a_stall, 4);
        a_send(8'h23, 111'h23);
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        a_valid_i = 1'b0;
        check("fl_valid", a_valid_o, 0);
        check("fl_ctrl",  a_ctrl_o, 0);
        check("fl_ready", a_ready_o, 1);
        check("fl_stall", a_stall, 5);
        a_ready_i = 1'b1;
        tick();
        check("fl_no_ghost", a_valid_o, 0);

        // Saturation of the 4-bit stall counter.
        a_ready_i = 1'b0;
        a_send(8'h31, 111'h31);
        tick();
        a_valid_i = 1'b0;
        for (int k = 0; k < 21; k++) tick();
        check("sat_stall", a_stall, 15);
        check("sat_head",  a_data_o, 'h31);

        // Reset while full discards both entries.
        a_send(8'h32, 111'h32);
        tick();
        check("rst_two_ready", a_ready_o, 0);
        a_valid_i = 1'b0;
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        check("rst_mid_valid", a_valid_o, 0);
        check("rst_mid_stall", a_stall, 0);
        check("rst_mid_data",  a_data_o, 0);
        check("rst_mid_ready", a_ready_o, 1);
        a_ready_i = 1'b1;
        tick();
        check("rst_mid_noskid", a_valid_o, 0);

        // Non-skid mode: ready_o follows ready_i combinationally when occupied.
        b_valid_i = 1'b1; b_ctrl_i = 8'h41; b_data_i = 111'h41;
        tick();
        check("nf_one_valid", b_valid_o, 1);
        check("nf_one_data",  b_data_o, 'h41);
        check("nf_ready_lo",  b_ready_o, 0);
        b_ready_i = 1'b1;
        #1;
        check("nf_ready_hi", b_ready_o, 1);
        b_ctrl_i = 8'h42; b_data_i = 111'h42;
        tick();
        check("nf_repl1", b_data_o, 'h42);
        check("nf_repl1c", b_ctrl_o, 'h42);
        b_ctrl_i = 8'h43; b_data_i = 111'h43;
        tick();
        check("nf_repl2", b_data_o, 'h43);
        check("nf_stall0", b_stall, 0);
        b_valid_i = 1'b0;
        b_ready_i = 1'b0;
        tick();
        check("nf_hold", b_data_o, 'h43);
        check("nf_stall1", b_stall, 1);
        check("nf_hold_ready", b_ready_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter CTRL_W, default 8, SHALL set control-field width (RegDst, ALUSrc, ALUOp[1:0], MemRead, MemWrite, MemtoReg, RegWrite packing).
REQ-002 Parameter DATA_W, default 111, SHALL set payload width (RSdata, RTdata, immediate, RS/RT/RD addresses).
REQ-003 Parameter SKID, default 1, SHALL select the mode: 1 = two-entry skid buffer with registered ready_o; 0 = single entry with combinational ready_o.
REQ-004 Parameter CNT_W, default 16, SHALL set the stall-counter width.
REQ-005 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 valid_i  in  1  upstream beat present.
REQ-008 ready_o  out  1  stage can accept a beat this cycle.
REQ-009 ctrl_i  in  CTRL_W  upstream control bits.
REQ-010 data_i  in  DATA_W  upstream payload.
REQ-011 flush_i  in  1  discard all held and incoming beats (hazard or branch kill).
REQ-012 valid_o  out  1  downstream beat present.
REQ-013 ready_i  in  1  downstream accepts the beat.
REQ-014 ctrl_o  out  CTRL_W  control bits of the head beat; forced to 0 when valid_o=0.
REQ-015 data_o  out  DATA_W  payload of the head beat; holds its last value when valid_o=0.
REQ-016 stall_cnt_o  out  CNT_W  saturating count of cycles with valid_o=1 and ready_i=0.

Function
REQ-017 accept = valid_i & ready_o; drain = valid_o & ready_i; both evaluated in the same cycle.
REQ-018 States SHALL be EMPTY (valid_o=0), ONE (head only), and TWO (head plus skid entry, reachable only when SKID=1).
REQ-019 EMPTY: accept -> ONE with head loaded from ctrl_i/data_i; otherwise stay.
REQ-020 ONE: accept & drain -> ONE, head reloaded; accept & !drain -> TWO, skid loaded (SKID=1 only); !accept & drain -> EMPTY; neither -> hold.
REQ-021 TWO: drain -> ONE with head <= skid entry; !drain -> hold; no accept possible.
REQ-022 SKID=1: ready_o SHALL be 1 in EMPTY and ONE and 0 in TWO; it is decoded only from the state register, with no combinational path from ready_i.
REQ-023 SKID=0: ready_o SHALL be ready_i | (state==EMPTY); TWO is unreachable.
REQ-024 Latency: an accepted beat SHALL appear on valid_o/ctrl_o/data_o the cycle after acceptance when the stage was EMPTY or draining.
REQ-025 Ordering: beats SHALL leave in acceptance order, and none SHALL be duplicated or lost unless flushed.
REQ-026 flush_i=1 SHALL force the next state to EMPTY and drop the same-cycle incoming beat; a same-cycle drain still completes downstream.
REQ-027 Flush priority: rst_i > flush_i > normal transitions.
REQ-028 stall_cnt_o SHALL increment by 1 each cycle valid_o=1 & ready_i=0, saturate at 2^CNT_W-1, and not clear on flush.

Reset
REQ-029 While rst_i=1 at a rising edge, the block SHALL go to state EMPTY and set valid_o=0, ctrl_o=0, data_o=0, skid entry=0, and stall_cnt_o=0.
REQ-030 After reset, ready_o SHALL be 1 in both modes.
REQ-031 Reset asserted mid-transfer (state TWO) SHALL discard both entries within one cycle.

Verification
REQ-032 SKID=1, ready_i=1, valid_i=1 every cycle with data 1,2,3,... -> data_o=1,2,3,... one cycle later, ready_o constantly 1.
REQ-033 SKID=1: send A, then hold ready_i=0 while offering B -> TWO, ready_o=0, and stall_cnt_o counts 1,2,3; on ready_i=1, A then B drain in order.
REQ-034 SKID=0, ready_i=0 in ONE -> ready_o=0 in the same cycle; with ready_i=1 and valid_i=1 the head is replaced every cycle.
REQ-035 Flush in TWO with valid_i=1 -> next cycle valid_o=0, ctrl_o=0, ready_o=1; the offered beat never appears.
REQ-036 Hold ready_i=0 with valid_o=1 for 2^CNT_W+5 cycles (CNT_W=4) -> stall_cnt_o stops at 15.
REQ-037 Assert rst_i in TWO -> next cycle valid_o=0, stall_cnt_o=0, data_o=0.
